uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter SOF, default 8'hA5, meaning start-of-frame byte.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the maximum number of clk cycles allowed between bytes inside a frame.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port rx_data, input, 8, the received byte from the UART receiver.
REQ-006 SHALL have port rx_done, input, 1, a one-cycle strobe marking rx_data valid.
REQ-007 SHALL have port wr_en, output, 1, a one-cycle register-write request.
REQ-008 SHALL have port rd_en, output, 1, a one-cycle register-read request.
REQ-009 SHALL have port addr, output, 8, the request address.
REQ-010 SHALL have port wdata, output, 8, the write data.
REQ-011 SHALL have port err, output, 1, a one-cycle frame-error strobe.
REQ-012 SHALL have port err_code, output, 2: 01 = checksum, 10 = unknown command, 11 = timeout.
REQ-013 SHALL have port busy, output, 1, high while the FSM is not in IDLE.

Function
REQ-014 Frame format SHALL be SOF, CMD, ADDR, DATA, CHK, where CHK = CMD ^ ADDR ^ DATA.
REQ-015 CMD values SHALL be 8'h01 = write and 8'h02 = read; for a read, the DATA byte is present but ignored.
REQ-016 FSM states SHALL be IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK.
REQ-017 All transitions SHALL happen only on cycles where rx_done=1, except a timeout abort.
REQ-018 In IDLE, a byte equal to SOF SHALL move the FSM to GET_CMD.
REQ-019 In IDLE, any other byte SHALL be discarded silently, with no err.
REQ-020 The FSM SHALL advance GET_CMD->GET_ADDR->GET_DATA->GET_CHK on each rx_done, latching CMD, ADDR and DATA respectively.
REQ-021 A SOF value received in GET_CMD..GET_CHK SHALL be treated as an ordinary data byte, with no resync.
REQ-022 On rx_done in GET_CHK, the FSM SHALL return to IDLE and evaluate the frame in the same edge.
REQ-023 If CHK mismatches, the block SHALL pulse err with code 01, and wr_en/rd_en SHALL stay low.
REQ-024 If CHK matches and CMD=01, the block SHALL pulse wr_en with addr=ADDR and wdata=DATA.
REQ-025 If CHK matches and CMD=02, the block SHALL pulse rd_en with addr=ADDR; wdata is unchanged.
REQ-026 If CHK matches and CMD is any other value, the block SHALL pulse err with code 10.
REQ-027 Checksum error SHALL take precedence over unknown command.
REQ-028 Latency: wr_en, rd_en and err SHALL go high on the cycle immediately after the rx_done cycle carrying CHK, and last exactly one cycle.
REQ-029 addr, wdata and err_code SHALL be registered and hold their values until the next update.
REQ-030 The timeout counter SHALL clear on every rx_done and while in IDLE, and otherwise increment by 1 per clk, saturating.
REQ-031 When the counter reaches TIMEOUT_CYCLES in a non-IDLE state, the FSM SHALL go to IDLE and pulse err with code 11 the next cycle.
REQ-032 rx_done in the same cycle the counter would reach TIMEOUT_CYCLES SHALL win: the byte is accepted, the counter clears, and there is no timeout.
REQ-033 At most one of wr_en, rd_en and err SHALL be high in any cycle.
REQ-034 busy SHALL be high in GET_CMD..GET_CHK and low in IDLE.
REQ-035 Back-to-back frames SHALL be accepted with no gap; a SOF byte arriving the cycle after CHK SHALL start a new frame.

Reset
REQ-036 When rst=1 at a clk edge, the FSM SHALL be set to IDLE.
REQ-037 When rst=1 at a clk edge, the timeout counter and the CMD/ADDR/DATA latches SHALL be set to 0.
REQ-038 When rst=1 at a clk edge, wr_en, rd_en, err and busy SHALL be set to 0.
REQ-039 When rst=1 at a clk edge, addr, wdata and err_code SHALL be set to 0.
REQ-040 Reset SHALL take priority over rx_done.
REQ-041 rst asserted mid-frame SHALL discard the partial frame with no err pulse.

Verification
REQ-042 Bytes A5,01,10,3C,2D -> one-cycle wr_en the cycle after the last rx_done, with addr=10 and wdata=3C.
REQ-043 Bytes A5,02,44,00,46 -> one-cycle rd_en with addr=44, and wr_en stays 0.
REQ-044 Bytes A5,01,10,3C,00 -> err=1 with err_code=01, and no wr_en or rd_en.
REQ-045 Bytes A5,07,00,00,07 -> err with err_code=10.
REQ-046 Bytes 00,FF,A5,01 then no rx_done for TIMEOUT_CYCLES cycles -> no err for the leading garbage; err with code 11; busy falls; a following valid frame is accepted.
REQ-047 rst pulsed after A5,01 -> all outputs 0, and the next valid frame parses correctly.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: SOF, CMD, ADDR, DATA, CHK frames turned into
// one-cycle register write/read requests, with checksum and timeout errors.
module uart_cmd_parser #(
    parameter logic [7:0] SOF            = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       wr_en,
    output logic       rd_en,
    output logic [7:0] addr,
    output logic [7:0] wdata,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    localparam logic [1:0] E_CHK = 2'b01;
    localparam logic [1:0] E_CMD = 2'b10;
    localparam logic [1:0] E_TMO = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_CHK
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    adr_q, adr_d;
    logic [7:0]    dat_q, dat_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          wr_d, rd_d, err_d;
    logic [1:0]    code_d;
    logic [7:0]    addr_d, wdata_d;
    logic          chk_ok, timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            cnt_q    <= '0;
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
            err      <= 1'b0;
            err_code <= '0;
            addr     <= '0;
            wdata    <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            cnt_q    <= cnt_d;
            wr_en    <= wr_d;
            rd_en    <= rd_d;
            err      <= err_d;
            err_code <= code_d;
            addr     <= addr_d;
            wdata    <= wdata_d;
        end
    end

    // Counter measures the gap since the last byte; an arriving byte always
    // beats a timeout that would fire on the same edge.
    always_comb begin
        if (state_q == IDLE || rx_done) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign timeout = (state_q != IDLE) && !rx_done && (cnt_q == CNT_LAST);
    assign chk_ok  = (rx_data == (cmd_q ^ adr_q ^ dat_q));

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = err_code;
        addr_d  = addr;
        wdata_d = wdata;

        if (timeout) begin
            state_d = IDLE;
            err_d   = 1'b1;
            code_d  = E_TMO;
        end else if (rx_done) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_data == SOF) begin
                        state_d = GET_CMD;
                    end
                end
                GET_CMD: begin
                    cmd_d   = rx_data;
                    state_d = GET_ADDR;
                end
                GET_ADDR: begin
                    adr_d   = rx_data;
                    state_d = GET_DATA;
                end
                GET_DATA: begin
                    dat_d   = rx_data;
                    state_d = GET_CHK;
                end
                GET_CHK: begin
                    state_d = IDLE;
                    if (!chk_ok) begin
                        err_d  = 1'b1;
                        code_d = E_CHK;
                    end else if (cmd_q == CMD_WR) begin
                        wr_d    = 1'b1;
                        addr_d  = adr_q;
                        wdata_d = dat_q;
                    end else if (cmd_q == CMD_RD) begin
                        rd_d   = 1'b1;
                        addr_d = adr_q;
                    end else begin
                        err_d  = 1'b1;
                        code_d = E_CMD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: frame-level model compared every cycle,
// plus directed frames with literal expectations.
module tb_uart_cmd_parser;

    localparam int         T   = 20;
    localparam logic [7:0] SOF = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       wr_en, rd_en, err, busy;
    logic [7:0] addr, wdata;
    logic [1:0] err_code;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .SOF(SOF),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .addr(addr),
        .wdata(wdata),
        .err(err),
        .err_code(err_code),
        .busy(busy)
    );

    // Frame-level model: a queue of bytes collected since SOF and a count of
    // silent cycles inside a frame.
    logic [7:0] fq[$];
    int         idle_n = 0;
    bit         mvalid = 0;
    logic       m_wr = 0, m_rd = 0, m_err = 0, m_busy = 0;
    logic [1:0] m_code = 0;
    logic [7:0] m_addr = 0, m_wdata = 0;

    always @(posedge clk) begin : model
        logic       w, r, e;
        logic [1:0] c;
        logic [7:0] a, d;
        w = 0; r = 0; e = 0;
        c = m_code; a = m_addr; d = m_wdata;
        if (rst) begin
            fq.delete();
            idle_n = 0;
            c = 0; a = 0; d = 0;
        end else if (rx_done) begin
            idle_n = 0;
            if (fq.size() != 0 || rx_data == SOF) fq.push_back(rx_data);
            if (fq.size() == 5) begin
                if (fq[4] != (fq[1] ^ fq[2] ^ fq[3])) begin
                    e = 1; c = 2'd1;
                end else if (fq[1] == 8'h01) begin
                    w = 1; a = fq[2]; d = fq[3];
                end else if (fq[1] == 8'h02) begin
                    r = 1; a = fq[2];
                end else begin
                    e = 1; c = 2'd2;
                end
                fq.delete();
            end
        end else if (fq.size() != 0) begin
            idle_n++;
            if (idle_n == T) begin
                e = 1; c = 2'd3;
                fq.delete();
                idle_n = 0;
            end
        end
        m_wr    <= w;
        m_rd    <= r;
        m_err   <= e;
        m_code  <= c;
        m_addr  <= a;
        m_wdata <= d;
        m_busy  <= (fq.size() != 0);
        mvalid  <= 1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            checks++;
            if ({wr_en, rd_en, err, err_code, addr, wdata, busy} ===
                {m_wr, m_rd, m_err, m_code, m_addr, m_wdata, m_busy}) begin
                passed++;
            end else begin
                $display("FAIL cycle_cmp t=%0t got wr%b rd%b err%b code%b a%h d%h busy%b expected wr%b rd%b err%b code%b a%h d%h busy%b",
                         $time, wr_en, rd_en, err, err_code, addr, wdata, busy,
                         m_wr, m_rd, m_err, m_code, m_addr, m_wdata, m_busy);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic put(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3,
                         input logic [7:0] b4);
        put(b0); put(b1); put(b2); put(b3); put(b4);
    endtask

    initial begin
        rst     = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("rst_wr", wr_en, 0);
        check("rst_rd", rd_en, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_code", err_code, 0);
        rst = 1'b0;

        frame(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D);
        check("wr_pulse", wr_en, 1);
        check("wr_addr", addr, 8'h10);
        check("wr_wdata", wdata, 8'h3C);
        check("wr_no_rd", rd_en, 0);
        @(negedge clk);
        check("wr_one_cycle", wr_en, 0);
        check("wr_addr_hold", addr, 8'h10);

        frame(8'hA5, 8'h02, 8'h44, 8'h00, 8'h46);
        check("rd_pulse", rd_en, 1);
        check("rd_no_wr", wr_en, 0);
        check("rd_addr", addr, 8'h44);
        check("rd_wdata_kept", wdata, 8'h3C);

        frame(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h00);
        check("chk_err", err, 1);
        check("chk_code", err_code, 2'b01);
        check("chk_no_wr", wr_en, 0);
        check("chk_addr_kept", addr, 8'h44);

        frame(8'hA5, 8'h07, 8'h00, 8'h00, 8'h07);
        check("cmd_err", err, 1);
        check("cmd_code", err_code, 2'b10);

        frame(8'hA5, 8'h07, 8'h00, 8'h00, 8'h00);
        check("prec_code", err_code, 2'b01);

        frame(8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h01);
        check("sof_data_wr", wr_en, 1);
        check("sof_data_addr", addr, 8'hA5);

        frame(8'hA5, 8'h01, 8'h20, 8'h55, 8'h74);
        check("b2b_wr", wr_en, 1);
        check("b2b_wdata", wdata, 8'h55);
        frame(8'hA5, 8'h02, 8'h30, 8'h00, 8'h32);
        check("b2b_rd", rd_en, 1);
        check("b2b_addr", addr, 8'h30);

        put(8'h00);
        put(8'hFF);
        check("garbage_no_err", err, 0);
        check("garbage_idle", busy, 0);
        put(8'hA5);
        put(8'h01);
        repeat (T - 1) @(negedge clk);
        check("tmo_not_yet", err, 0);
        check("tmo_busy", busy, 1);
        @(negedge clk);
        check("tmo_err", err, 1);
        check("tmo_code", err_code, 2'b11);
        check("tmo_busy_fall", busy, 0);
        @(negedge clk);
        check("tmo_one_cycle", err, 0);
        frame(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D);
        check("post_tmo_wr", wr_en, 1);

        put(8'hA5);
        repeat (T - 1) @(negedge clk);
        put(8'h01);
        check("edge_no_tmo", err, 0);
        check("edge_busy", busy, 1);
        put(8'h66); put(8'h77); put(8'h10);
        check("edge_wr", wr_en, 1);
        check("edge_addr", addr, 8'h66);

        put(8'hA5);
        put(8'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_wdata", wdata, 0);
        check("mid_rst_err", err, 0);
        @(negedge clk);
        check("mid_rst_no_err", err, 0);
        frame(8'hA5, 8'h02, 8'h44, 8'h00, 8'h46);
        check("post_rst_rd", rd_en, 1);
        check("post_rst_addr", addr, 8'h44);

        rst = 1'b1;
        put(SOF);
        rst = 1'b0;
        check("rst_over_rx", busy, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
